// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ producers,
// moving up to MAX_BURST words per grant and stalling on FIFO full.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  localparam int OW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               fifo_full,
  output logic [NREQ-1:0]    req_ack,
  output logic               fifo_w_en,
  output logic [DW-1:0]      fifo_in_data,
  output logic [OW-1:0]      owner,
  output logic               busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  state_e          state_q;
  logic [OW-1:0]   rr_ptr_q;
  logic [OW-1:0]   owner_q;
  logic [3:0]      burst_cnt_q;

  logic [OW-1:0]   pick_s;
  logic            pick_vld_s;
  logic [OW-1:0]   idx_s;
  logic [OW-1:0]   owner_inc_s;
  logic            write_s;
  logic            last_word_s;

  // Search downward so the requester closest to rr_ptr is the last one kept.
  always_comb begin
    pick_s     = rr_ptr_q;
    pick_vld_s = 1'b0;
    idx_s      = rr_ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_s = OW'((int'(rr_ptr_q) + k) % NREQ);
      if (req[idx_s]) begin
        pick_s     = idx_s;
        pick_vld_s = 1'b1;
      end else begin
        pick_s     = pick_s;
        pick_vld_s = pick_vld_s;
      end
    end
  end

  assign owner_inc_s = (owner_q == OW'(NREQ - 1)) ? {OW{1'b0}} : owner_q + OW'(1);
  assign last_word_s = (burst_cnt_q == 4'(MAX_BURST - 1));
  assign write_s     = !rst && (state_q == S_BURST) && req[owner_q] && !fifo_full;

  // One-hot acknowledge for the word accepted this cycle.
  always_comb begin
    req_ack = {NREQ{1'b0}};
    if (write_s) begin
      req_ack[owner_q] = 1'b1;
    end else begin
      req_ack = {NREQ{1'b0}};
    end
  end

  assign fifo_w_en    = write_s;
  assign fifo_in_data = req_data[owner_q*DW +: DW];
  assign owner        = owner_q;
  assign busy         = (state_q == S_BURST);

  // Grant FSM: a dropped request outranks a full FIFO when releasing the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= {OW{1'b0}};
      owner_q     <= {OW{1'b0}};
      burst_cnt_q <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld_s) begin
            owner_q     <= pick_s;
            burst_cnt_q <= 4'd0;
            state_q     <= S_BURST;
          end else begin
            state_q     <= S_IDLE;
          end
        end
        S_BURST: begin
          if (!req[owner_q]) begin
            rr_ptr_q <= owner_inc_s;
            state_q  <= S_IDLE;
          end else if (fifo_full) begin
            state_q  <= S_BURST;
          end else begin
            burst_cnt_q <= burst_cnt_q + 4'd1;
            if (last_word_s) begin
              rr_ptr_q <= owner_inc_s;
              state_q  <= S_IDLE;
            end else begin
              state_q  <= S_BURST;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producers are modelled as word lists,
// expected writes (owner, data, cycle gap since previous write) are queued by the stimulus.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        fifo_full;
  logic [3:0]  req_ack;
  logic        fifo_w_en;
  logic [7:0]  fifo_in_data;
  logic [1:0]  owner;
  logic        busy;

  fifo_wr_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .fifo_full    (fifo_full),
    .req_ack      (req_ack),
    .fifo_w_en    (fifo_w_en),
    .fifo_in_data (fifo_in_data),
    .owner        (owner),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         own;
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pmem [4][32];
  int         phead [4];
  int         ptail [4];
  logic [3:0] ack_seen = 4'b0000;
  int         passed = 0;
  int         total = 0;
  int         cyc = 0;
  int         last_wr = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic give(input int p, input logic [7:0] d);
    pmem[p][ptail[p]] = d;
    ptail[p]++;
  endtask

  task automatic expect_w(input int own, input logic [7:0] d, input int gap);
    exp_t e;
    e.own  = own;
    e.data = d;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      if (phead[i] != ptail[i]) begin
        req[i]            = 1'b1;
        req_data[i*8 +: 8] = pmem[i][phead[i]];
      end else begin
        req[i]            = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
      end
    end
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk(1'b0, "drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_writes(input int n, input int maxc);
    int seen;
    int k;
    seen = 0;
    k = 0;
    while (seen < n && k < maxc) begin
      @(negedge clk);
      k++;
      if (fifo_w_en) seen++;
    end
    if (seen < n) chk(1'b0, "wait_timeout", seen, n);
  endtask

  // Capture acknowledges mid-cycle; they are consumed at the following edge.
  initial begin
    forever begin
      @(negedge clk);
      ack_seen = req_ack;
    end
  end

  // Producers: advance on acknowledge, present the next word just after the edge.
  initial begin
    #1;
    drive_inputs();
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (ack_seen[i] && phead[i] != ptail[i]) phead[i]++;
      end
      drive_inputs();
    end
  end

  // Monitor: compare each FIFO write against the scoreboard.
  initial begin
    exp_t       e;
    logic [3:0] exp_ack;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk(!fifo_w_en && req_ack == 4'b0000, "rst_no_write", {27'd0, fifo_w_en, req_ack}, 0);
      end else if (fifo_full) begin
        chk(!fifo_w_en && req_ack == 4'b0000, "full_no_write", {27'd0, fifo_w_en, req_ack}, 0);
      end
      if (fifo_w_en) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_write", int'(fifo_in_data), 0);
        end else begin
          e = exp_q.pop_front();
          exp_ack = 4'b0001 << e.own;
          chk(fifo_in_data == e.data, "wdata", int'(fifo_in_data), int'(e.data));
          chk(req_ack == exp_ack, "ack", int'(req_ack), int'(exp_ack));
          chk(int'(owner) == e.own, "owner", int'(owner), e.own);
          if (e.gap != 0) chk(cyc - last_wr == e.gap, "gap", cyc - last_wr, e.gap);
        end
        last_wr = cyc;
      end
    end
  end

  initial begin
    rst       = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      phead[i] = 0;
      ptail[i] = 0;
    end

    // T1: reset with all requesting, then one word each in order 0..3
    for (int p = 0; p < 4; p++) begin
      give(p, 8'h10 + 8'(p));
      expect_w(p, 8'h10 + 8'(p), (p == 0) ? 0 : 3);
    end
    repeat (2) begin
      @(negedge clk);
      chk(fifo_w_en == 1'b0, "reset_w_en", int'(fifo_w_en), 0);
      chk(req_ack == 4'b0000, "reset_ack", int'(req_ack), 0);
      chk(busy == 1'b0, "reset_busy", int'(busy), 0);
      chk(owner == 2'd0, "reset_owner", int'(owner), 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    drain(200);

    // T3: all request; bursts of 4 in order 0,1,2,3,0 with one idle cycle between
    for (int w = 0; w < 8; w++) give(0, 8'h20 + 8'(w));
    for (int p = 1; p < 4; p++) begin
      for (int w = 0; w < 4; w++) give(p, 8'h20 + 8'(p * 16) + 8'(w));
    end
    for (int p = 0; p < 4; p++) begin
      for (int w = 0; w < 4; w++)
        expect_w(p, 8'h20 + 8'(p * 16) + 8'(w), (w == 0) ? ((p == 0) ? 0 : 2) : 1);
    end
    for (int w = 4; w < 8; w++) expect_w(0, 8'h20 + 8'(w), (w == 4) ? 2 : 1);
    drain(200);

    // T2: single producer 2, six words
    for (int w = 0; w < 6; w++) give(2, 8'hA0 + 8'(w));
    expect_w(2, 8'hA0, 0);
    expect_w(2, 8'hA1, 1);
    expect_w(2, 8'hA2, 1);
    expect_w(2, 8'hA3, 1);
    expect_w(2, 8'hA4, 2);
    expect_w(2, 8'hA5, 1);
    drain(200);

    // T4: producer 1 stalled by full for burst cycles 2-4
    for (int w = 0; w < 4; w++) give(1, 8'h60 + 8'(w));
    expect_w(1, 8'h60, 0);
    expect_w(1, 8'h61, 4);
    expect_w(1, 8'h62, 1);
    expect_w(1, 8'h63, 1);
    wait_writes(1, 50);
    @(posedge clk);
    #1 fifo_full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk(busy == 1'b1, "stall_busy", int'(busy), 1);
    end
    @(posedge clk);
    #1 fifo_full = 1'b0;
    drain(200);

    // T5: producer 3 drops after 2 words (with full in the release cycle), then 0
    give(3, 8'h70);
    give(3, 8'h71);
    give(0, 8'h80);
    expect_w(3, 8'h70, 0);
    expect_w(3, 8'h71, 1);
    expect_w(0, 8'h80, 3);
    wait_writes(2, 50);
    @(posedge clk);
    #1 fifo_full = 1'b1;
    @(posedge clk);
    #1 fifo_full = 1'b0;
    drain(200);

    // T6: reset after owner 2's second write; next grant searches from 0
    for (int w = 0; w < 6; w++) give(2, 8'h90 + 8'(w));
    give(0, 8'hB0);
    expect_w(2, 8'h90, 0);
    expect_w(2, 8'h91, 1);
    expect_w(0, 8'hB0, 3);
    expect_w(2, 8'h92, 3);
    expect_w(2, 8'h93, 1);
    expect_w(2, 8'h94, 1);
    expect_w(2, 8'h95, 1);
    wait_writes(2, 50);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(busy == 1'b0, "post_rst_busy", int'(busy), 0);
    chk(owner == 2'd0, "post_rst_owner", int'(owner), 0);
    drain(200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
